rf_dump: RTL
============

RF_DUMP -- requirements
Module: rf_dump

Interface
REQ-001 The block SHALL have parameter NREG, default 32, meaning the number of registers dumped; legal range 2..32.
REQ-002 The block SHALL have parameter FIRST, default 0, meaning the index of the first register dumped; FIRST < NREG.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to begin a dump, sampled in IDLE only.
REQ-006 Port reg_sel, output, 5 bits: register-file debug read index, registered.
REQ-007 Port reg_data, input, 32 bits: register-file debug read data, combinational from reg_sel; index 0 reads 0.
REQ-008 Port tx_data, output, 8 bits: byte stream data.
REQ-009 Port tx_valid, output, 1 bit: tx_data holds a valid byte.
REQ-010 Port tx_ready, input, 1 bit: the downstream sink accepts the byte when tx_valid and tx_ready are both high on a clock edge.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse when the last byte has been accepted.

Function
REQ-013 The FSM SHALL have the states IDLE, SEL, LOAD, SEND and DONE.
REQ-014 IDLE with start=1: reg_sel<=FIRST, next state SEL; start=0 stays in IDLE.
REQ-015 SEL SHALL last exactly one cycle so that reg_data settles, then go to LOAD.
REQ-016 LOAD SHALL capture reg_data into a 32-bit shift register, clear the 2-bit byte counter and go to SEND.
REQ-017 In SEND, tx_valid=1 and tx_data=shift[31:24]; bytes go out MSB first.
REQ-018 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold stable.
REQ-019 On acceptance with count<3: shift left by 8 and count+1, staying in SEND.
REQ-020 On acceptance with count==3 and reg_sel<NREG-1: reg_sel+1, next state SEL.
REQ-021 On acceptance with count==3 and reg_sel==NREG-1: go to DONE.
REQ-022 In DONE, done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-023 tx_valid SHALL be 0 in IDLE, SEL, LOAD and DONE.
REQ-024 The minimum spacing between registers SHALL be 2 bubble cycles (SEL and LOAD); with tx_ready held at 1 the total is 6*(NREG-FIRST)+2 cycles from start to done inclusive.
REQ-025 The block SHALL emit exactly 4*(NREG-FIRST) bytes per dump.
REQ-026 Register r SHALL be sampled only in its own LOAD cycle; a register-file write after that sample is not reflected; the dump is not an atomic snapshot.
REQ-027 start asserted while busy=1 SHALL be ignored, not queued.
REQ-028 start asserted in the same cycle as done=1 SHALL be ignored; a new dump starts on start in IDLE only.

Reset
REQ-029 rst_n=0 SHALL force, asynchronously: state=IDLE, reg_sel=0, tx_data=0, tx_valid=0, busy=0, done=0, shift register=0, byte count=0.
REQ-030 Reset mid-dump SHALL abandon the dump immediately, and the partial byte SHALL NOT be re-emitted after release.
REQ-031 After rst_n rises, the first dump SHALL start only on a fresh start in IDLE.

Structure
REQ-032 Package rf_dump_pkg SHALL hold the FSM state enum, the byte-count width (2) and the bytes-per-register constant (4).
REQ-033 A single sub-module rf_dump_ser SHALL implement the 32-to-8 shift register, byte counter and valid/ready hold.
REQ-034 The FSM and reg_sel counter SHALL remain in the top level.

Verification
REQ-035 Defaults, RF preloaded r1=0x11223344 and r31=0xDEADBEEF, tx_ready=1, start pulse -> 128 bytes; bytes 4..7 = 11,22,33,44; last 4 = DE,AD,BE,EF; bytes 0..3 = 00; done at cycle 194.
REQ-036 tx_ready toggled randomly with 50% duty -> byte sequence identical to REQ-035; tx_data stable during every stall.
REQ-037 FIRST=30, NREG=32, r30=0xCAFEF00D -> 8 bytes CA,FE,F0,0D,DE,AD,BE,EF, then a single done pulse.
REQ-038 start pulsed again at byte 10 -> ignored, exactly 128 bytes total; start in the done cycle -> no new dump.
REQ-039 rst_n low at byte 50 -> tx_valid=0 and busy=0 within the same cycle; a new start after release yields a full 128-byte dump from r0.
REQ-040 r5 written 0x0 -> 0xFFFFFFFF during r3's SEND -> the dump shows r5=FF,FF,FF,FF; written during r6's SEND -> the dump shows r5 with its old value.

Source files
------------

// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared types and constants for the register-file dumper.
//   state_e       - sequencing FSM states
//   CNT_W         - width of the per-register byte counter
//   BYTES_PER_REG - bytes emitted for each 32-bit register
package rf_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_e;

    localparam int CNT_W         = 2;
    localparam int BYTES_PER_REG = 4;

endpackage

// File: rtl/rf_dump_ser.sv
// rf_dump_ser: 32-to-8 serializer with byte counter and valid/ready hold.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   load_i       - capture data_i and clear the byte counter
//   send_i       - FSM is in SEND; drives tx_valid_o
//   ready_i      - downstream ready
//   data_i       - 32-bit register word to serialize
//   tx_data_o    - current byte (MSB first)
//   tx_valid_o   - byte valid
//   accept_o     - byte accepted this cycle (valid & ready)
//   last_o       - current byte is the last of the word
module rf_dump_ser
    import rf_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        send_i,
    input  logic        ready_i,
    input  logic [31:0] data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        accept_o,
    output logic        last_o
);

    logic [31:0]      shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tx_valid_o = send_i;
    assign tx_data_o  = shift_q[31:24];
    assign accept_o   = send_i && ready_i;
    assign last_o     = (cnt_q == CNT_W'(BYTES_PER_REG - 1));

    // On the last byte nothing shifts; the FSM leaves SEND and the next
    // LOAD overwrites the register anyway.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = '0;
        end else if (accept_o && !last_o) begin
            shift_d = {shift_q[23:0], 8'h00};
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/rf_dump.sv
// rf_dump: streams registers FIRST..NREG-1 of a register file as bytes,
// MSB first, over a valid/ready byte interface.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   start      - begin a dump (honoured in IDLE only)
//   reg_sel    - registered register-file read index
//   reg_data   - register-file read data (combinational from reg_sel)
//   tx_data    - output byte
//   tx_valid   - output byte valid
//   tx_ready   - downstream ready
//   busy       - dump in progress (any state but IDLE)
//   done       - one-cycle pulse after the last byte is accepted
//
// state | meaning
// IDLE  | waiting for start
// SEL   | reg_sel just updated, let reg_data settle
// LOAD  | capture reg_data into the serializer
// SEND  | emit 4 bytes of the captured word
// DONE  | single-cycle done pulse
module rf_dump
    import rf_dump_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int FIRST = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    state_e     state_q, state_d;
    logic [4:0] reg_sel_q, reg_sel_d;
    logic       load;
    logic       accept;
    logic       last_byte;

    rf_dump_ser u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .send_i     (state_q == ST_SEND),
        .ready_i    (tx_ready),
        .data_i     (reg_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .accept_o   (accept),
        .last_o     (last_byte)
    );

    always_comb begin
        state_d   = state_q;
        reg_sel_d = reg_sel_q;
        load      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    reg_sel_d = 5'(FIRST);
                    state_d   = ST_SEL;
                end
            end
            ST_SEL:  state_d = ST_LOAD;
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (accept && last_byte) begin
                    if (reg_sel_q == 5'(NREG - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        reg_sel_d = reg_sel_q + 5'd1;
                        state_d   = ST_SEL;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            reg_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            reg_sel_q <= reg_sel_d;
        end
    end

    assign reg_sel = reg_sel_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule
